muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer that owns the HI/LO result path of the MIPS CPU's execute stage.
- The control unit issues MULT, MULTU, DIV or DIVU with the rs/rt operands.
- The block runs a 32-step shift-add multiply or restoring divide, holding the fetch stage stalled while it works.
- It then presents HI/LO plus a one-cycle write-enable for the hi/lo registers read by MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
ITERS, WIDTH, number of RUN iterations; fixed equal to WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset; asynchronous, active-high; all registers forced to reset values immediately.
start  input  1  request pulse from control unit; sampled only in IDLE.
op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start.
a  input  WIDTH  rs operand (multiplicand or dividend); sampled with start.
b  input  WIDTH  rt operand (multiplier or divisor); sampled with start.
busy  output  1  high in PREP, RUN and FIX.
stall_FETCH  output  1  combinational: (start and state==IDLE) or busy; freezes PC and the instruction register.
done  output  1  high exactly one cycle, in DONE.
enhilo  output  1  equals done; write-enable for the hi/lo registers.
hi  output  WIDTH  MULT: product[63:32]; DIV: remainder. Held between operations.
lo  output  WIDTH  MULT: product[31:0]; DIV: quotient. Held between operations.

Behaviour:
- Reset values: state=IDLE; busy, done, enhilo, stall_FETCH=0; hi=lo=0; internal counter and accumulators=0.
- States and transitions:
  - IDLE: start=1 at an edge captures op, a and b, then goes to PREP. start=0 stays in IDLE.
  - PREP: for signed ops, takes magnitudes of a and b and records the result sign and the remainder sign. Clears the 2*WIDTH accumulator and sets counter=0. Goes to RUN.
  - RUN: one iteration per cycle, counter increments.
    - Multiply: if multiplier LSB is 1, add the multiplicand to the upper half; then shift the accumulator right by 1.
    - Divide: shift remainder:quotient left by 1; trial subtract the divisor; if the result is non-negative, keep it and set quotient LSB=1.
    - Leaves RUN after counter reaches ITERS-1, i.e. exactly 32 RUN cycles.
  - FIX: applies signs.
    - MULT: 64-bit two's-complement negate if the operand signs differ.
    - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
    - Registers hi/lo. Goes to DONE.
  - DONE: done=enhilo=1 for one cycle. Goes to IDLE unconditionally.
- Latency: start accepted at edge N; done is high during the cycle after edge N+34; stall_FETCH is high from the cycle start is asserted until the end of the cycle after edge N+33. stall_FETCH is low in DONE.
- start while busy or in DONE: ignored. No queuing, and captured operands are unchanged.
- Divide by zero (b==0, DIV or DIVU): full latency still applies; sign fix is bypassed; lo=all ones, hi=a as captured.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is the natural magnitude-path result; no exception.
- Unsigned ops: no sign handling; the magnitudes are the raw operands.
- Width rules: the multiply accumulator is 2*WIDTH+1 bits to hold the carry; the divide trial subtract is WIDTH+1 bits.
- Reset mid-operation: returns to IDLE at once. hi/lo are cleared to 0; done/enhilo never pulse for the aborted op. The next start behaves normally.
- hi/lo change only on the FIX->DONE edge or at reset.

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum md_op_t {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  - typedef enum md_state_t {IDLE, PREP, RUN, FIX, DONE};
  - constant MD_ITERS=32.
- The control unit imports md_op_t to drive op.
- No sub-module; a single module holding both FSM and datapath is natural at this size.

Test Plan:
1. MULTU a=0xFFFFFFFF, b=2 -> done 34 cycles after accept; hi=0x00000001, lo=0xFFFFFFFE; enhilo one cycle; stall_FETCH high through RUN/FIX.
2. MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
3. DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
4. DIVU a=0x64, b=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
5. Second start pulsed in RUN cycle 5 with different operands -> ignored; results match the first op; exactly one done pulse.
6. Assert rst during RUN cycle 10 -> busy, stall_FETCH and done go to 0 immediately; hi=lo=0. Then MULTU 6*7 -> hi=0, lo=42 with normal latency.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_t;

  // Divide ops have op[1] set.
  function automatic logic md_is_div(input md_op_t o);
    return o[1];
  endfunction

  // Signed ops (MULT, DIV) have op[0] clear.
  function automatic logic md_is_signed(input md_op_t o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer driving the HI/LO registers.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the accepting edge
// PREP  | magnitudes and result signs computed, accumulator loaded
// RUN   | one shift-add or restoring-divide step per cycle, 32 cycles
// FIX   | signs applied (or divide-by-zero result forced), hi/lo loaded
// DONE  | done/enhilo pulse for one cycle, then back to IDLE
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall_FETCH,
  output logic             done,
  output logic             enhilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int AW = 2 * WIDTH + 1;

  localparam logic [2:0] S_IDLE = 3'(IDLE);
  localparam logic [2:0] S_PREP = 3'(PREP);
  localparam logic [2:0] S_RUN  = 3'(RUN);
  localparam logic [2:0] S_FIX  = 3'(FIX);
  localparam logic [2:0] S_DONE = 3'(DONE);

  localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

  logic [2:0]       state_q, state_d;
  md_op_t           op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             op_signed;
  logic             op_div;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next;
  logic [AW-1:0]    div_shift;
  logic [WIDTH:0]   div_trial;
  logic [AW-1:0]    div_next;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0] quo_mag;
  logic [WIDTH-1:0] rem_mag;

  assign op_signed = md_is_signed(op_q);
  assign op_div    = md_is_div(op_q);

  // Magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign mag_a = (op_signed && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
  assign mag_b = (op_signed && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;

  // Multiply step: conditional add into the upper half (carry kept in the top bit), then shift right.
  assign mul_sum  = acc_q[AW-1:WIDTH] + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? ({mul_sum, acc_q[WIDTH-1:0]} >> 1) : (acc_q >> 1);

  // Divide step: shift remainder:quotient left, trial subtract; the shifted remainder is below
  // twice the divisor, so bit WIDTH of the trial result is a reliable borrow.
  assign div_shift = {acc_q[AW-2:0], 1'b0};
  assign div_trial = div_shift[AW-1:WIDTH] - {1'b0, opnd_q};
  assign div_next  = div_trial[WIDTH] ? div_shift
                                      : {1'b0, div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};

  assign prod_mag = acc_q[2*WIDTH-1:0];
  assign prod_neg = ~prod_mag + 1'b1;
  assign quo_mag  = acc_q[WIDTH-1:0];
  assign rem_mag  = acc_q[2*WIDTH-1:WIDTH];

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = md_op_t'(op);
          a_d     = a;
          b_d     = b;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        neg_res_d = op_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_rem_d = op_signed & a_q[WIDTH-1];
        cnt_d     = '0;
        if (op_div) begin
          opnd_d = mag_b;
          acc_d  = {{(WIDTH + 1){1'b0}}, mag_a};
        end else begin
          opnd_d = mag_a;
          acc_d  = {{(WIDTH + 1){1'b0}}, mag_b};
        end
        state_d = S_RUN;
      end

      S_RUN: begin
        acc_d = op_div ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (op_div) begin
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = neg_res_q ? (~quo_mag + 1'b1) : quo_mag;
            hi_d = neg_rem_q ? (~rem_mag + 1'b1) : rem_mag;
          end
        end else begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : prod_mag;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= MD_MULT;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
  assign stall_FETCH = (start && (state_q == S_IDLE)) || busy;
  assign done        = (state_q == S_DONE);
  assign enhilo      = done;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Table-driven bench for muldiv_seq with a hi/lo scoreboard.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall_FETCH;
  logic        done;
  logic        enhilo;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_seq #(.WIDTH(32), .ITERS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .stall_FETCH (stall_FETCH),
    .done        (done),
    .enhilo      (enhilo),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t sb[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op and follow it to DONE; inj>0 pulses a second start after that edge,
  // rcyc>0 asserts reset after that edge instead of waiting for DONE.
  task automatic run_op(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int inj, input int rcyc);
    int   cyc;
    bit   stall_ok;
    bit   seen;
    int   dc0;
    res_t e;
    cyc = 0;
    stall_ok = 1'b1;
    seen = 1'b0;
    dc0 = done_cnt;
    @(negedge clk);
    op = o; a = ia; b = ib; start = 1'b1;
    #1 check("stall_on_start", 64'(stall_FETCH), 64'd1);
    @(posedge clk);
    sb.push_back('{hi: ehi, lo: elo});
    #1 start = 1'b0;
    while (cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (rcyc > 0 && cyc == rcyc) begin
        rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall_FETCH), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        void'(sb.pop_front());
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1 check("rst_no_done", 64'(done_cnt - dc0), 64'd0);
        return;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!stall_FETCH || !busy) stall_ok = 1'b0;
      if (cyc == inj) begin
        start = 1'b1; op = MD_MULTU; a = ~ia; b = ib + 32'd5;
      end
    end
    check("latency", 64'(cyc), 64'd34);
    check("stall_busy_span", 64'(stall_ok), 64'd1);
    if (seen) begin
      check("enhilo", 64'(enhilo), 64'd1);
      check("stall_in_done", 64'(stall_FETCH), 64'd0);
      check("busy_in_done", 64'(busy), 64'd0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
      end
      repeat (3) @(posedge clk);
      #1;
      check("done_once", 64'(done_cnt - dc0), 64'd1);
      check("hilo_held", {hi, lo}, {ehi, elo});
    end else begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4]  = '{MD_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[7]  = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[8]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vecs[11] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};

    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stall", 64'(stall_FETCH), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_enhilo", 64'(enhilo), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    #12 rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, 0, 0);
    end

    // Second start during RUN cycle 5 must be ignored.
    run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 6, 0);

    // Reset during RUN cycle 10, then a normal op.
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h0, 0, 11);
    run_op(MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 0, 0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
